// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and a FWFT byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    input  logic       i_rd,
    input  logic       i_clr_err,
    output logic [7:0] o_rd_data,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_Rx_Active,
    output logic       o_Rx_DV,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          rx_meta;
    logic          rx_s;
    logic          push_pend;

    // Preset high so reset release does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic parity_err_q;
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            rx_byte     <= '0;
            push_pend   <= 1'b0;
            o_Rx_Active <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push_pend   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state       <= DATA;
                            o_Rx_Active <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt          <= '0;
                        rx_byte[bit_idx] <= rx_s;
                        bit_idx          <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        par_bad <= (^rx_byte) ^ rx_s;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt     <= '0;
                        o_Rx_Active <= 1'b0;
                        if (rx_s) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) parity_err_q <= 1'b1;
                            else         push_pend    <= 1'b1;
`else
                            push_pend <= 1'b1;
`endif
                        end else begin
                            // Stop failure outranks parity failure.
                            o_frame_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        rd_en;
    logic        wr_en;

    assign o_empty   = (wr_ptr == rd_ptr);
    assign o_full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_en     = i_rd && !o_empty;
    // A same-cycle pop makes room, so a push into a full FIFO still lands.
    assign wr_en     = push_pend && (!o_full || rd_en);
    assign o_rd_data = o_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_Rx_DV   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_Rx_DV <= wr_en;
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push_pend && !wr_en) o_overrun <= 1'b1;
            else if (i_clr_err)      o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: single byte, burst, overrun, framing error, glitch, reset.
module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic       i_rd = 1'b0;
    logic       i_clr_err = 1'b0;
    logic [7:0] o_rd_data;
    logic       o_empty, o_full, o_Rx_Active, o_Rx_DV, o_frame_err, o_parity_err, o_overrun;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_Rx_Serial(pin), .i_rd(i_rd), .i_clr_err(i_clr_err),
        .o_rd_data(o_rd_data), .o_empty(o_empty), .o_full(o_full),
        .o_Rx_Active(o_Rx_Active), .o_Rx_DV(o_Rx_DV), .o_frame_err(o_frame_err),
        .o_parity_err(o_parity_err), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, act_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (o_Rx_DV) dv_cnt++;
        if (o_frame_err) fe_cnt++;
        if (o_parity_err) pe_cnt++;
        if (o_Rx_Active) act_cnt++;
        if (o_Rx_DV && o_frame_err) both_cnt++;
    end

    // Sole owner of i_rd; every popped byte is logged in got.
    logic [7:0] got[$];
    bit auto_pop = 1'b0;
    int pop_target = 0;
    int pops_done = 0;
    always @(negedge clk) begin
        i_rd = 1'b0;
        if (!rst && !o_empty && (auto_pop || pops_done < pop_target)) begin
            i_rd = 1'b1;
            got.push_back(o_rd_data);
            pops_done++;
        end
    end

    task automatic bit_out(input logic v, input int n);
        pin = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit flip_par, input int stop_n, input logic stop_v);
        bit_out(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_out(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        bit_out((^b) ^ flip_par, CPB);
`endif
        bit_out(stop_v, stop_n);
        pin = 1'b1;
    endtask

    task automatic idle(input int n);
        pin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("pop_wait", got.size(), n);
    endtask

    logic [7:0] burst [12];
    int base, dv0, fe0, act0;

    initial begin
        burst = '{8'h30, 8'h31, 8'h30, 8'h30, 8'h30, 8'h35,
                  8'h30, 8'h30, 8'h32, 8'h30, 8'h30, 8'h31};
        repeat (3) @(negedge clk);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_data", o_rd_data, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_active", o_Rx_Active, 0);
        chk("rst_pulses", {o_Rx_DV, o_frame_err, o_parity_err}, 0);
        rst = 1'b0;
        idle(4);

        // single byte
        send(8'h35, 0, CPB, 1'b1);
        idle(4);
        chk("single_dv", dv_cnt, 1);
        chk("single_empty", o_empty, 0);
        chk("single_data", o_rd_data, 8'h35);
        pop_target = pops_done + 1;
        wait_got(1);
        repeat (2) @(negedge clk);
        chk("single_pop_empty", o_empty, 1);

        // 12-byte report drained as it arrives
        base = got.size();
        dv0 = dv_cnt;
        auto_pop = 1'b1;
        for (int i = 0; i < 12; i++) send(burst[i], 0, CPB, 1'b1);
        idle(6);
        wait_got(base + 12);
        auto_pop = 1'b0;
        chk("burst_dv", dv_cnt - dv0, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("burst_b%0d", i), got[base + i], burst[i]);
        chk("burst_overrun", o_overrun, 0);

        // overrun: fifth byte dropped
        dv0 = dv_cnt;
        for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 0, CPB, 1'b1);
        idle(4);
        chk("ovr_full", o_full, 1);
        chk("ovr_no_flag_yet", o_overrun, 0);
        send(8'h45, 0, CPB, 1'b1);
        idle(4);
        chk("ovr_flag", o_overrun, 1);
        chk("ovr_dv", dv_cnt - dv0, 4);
        base = got.size();
        pop_target = pops_done + 4;
        wait_got(base + 4);
        for (int i = 0; i < 4; i++) chk($sformatf("ovr_b%0d", i), got[base + i], 8'h41 + 8'(i));
        repeat (2) @(negedge clk);
        chk("ovr_drained", o_empty, 1);
        chk("ovr_sticky", o_overrun, 1);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        chk("ovr_clr", o_overrun, 0);

        // framing error: stop held low for 3 bit-times
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send(8'h55, 0, 3 * CPB, 1'b0);
        idle(8);
        chk("fe_pulse", fe_cnt - fe0, 1);
        chk("fe_no_dv", dv_cnt - dv0, 0);
        chk("fe_empty", o_empty, 1);
        send(8'h66, 0, CPB, 1'b1);
        idle(4);
        chk("fe_next_dv", dv_cnt - dv0, 1);
        chk("fe_next_data", o_rd_data, 8'h66);
        pop_target = pops_done + 1;
        wait_got(got.size() + 1);
        repeat (2) @(negedge clk);

        // one-cycle glitch on the idle line
        act0 = act_cnt;
        pin = 1'b0;
        @(negedge clk);
        idle(12);
        chk("glitch_active", act_cnt - act0, 0);
        chk("glitch_empty", o_empty, 1);

        // reset mid-frame with a byte already queued
        send(8'h11, 0, CPB, 1'b1);
        idle(4);
        chk("pre_rst_empty", o_empty, 0);
        pin = 1'b0;
        repeat (CPB * 4) @(negedge clk);
        chk("mid_active", o_Rx_Active, 1);
        rst = 1'b1;
        #1;
        chk("async_empty", o_empty, 1);
        chk("async_active", o_Rx_Active, 0);
        chk("async_data", o_rd_data, 0);
        @(negedge clk);
        pin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        dv0 = dv_cnt;
        send(8'h7E, 0, CPB, 1'b1);
        idle(4);
        chk("post_rst_dv", dv_cnt - dv0, 1);
        chk("post_rst_data", o_rd_data, 8'h7E);
        pop_target = pops_done + 1;
        wait_got(got.size() + 1);
        repeat (2) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        dv0 = dv_cnt;
        send(8'h03, 0, CPB, 1'b1);
        idle(4);
        chk("par_ok_dv", dv_cnt - dv0, 1);
        chk("par_ok_data", o_rd_data, 8'h03);
        pop_target = pops_done + 1;
        wait_got(got.size() + 1);
        repeat (2) @(negedge clk);
        dv0 = dv_cnt;
        fe0 = pe_cnt;
        send(8'h03, 1, CPB, 1'b1);
        idle(4);
        chk("par_bad_pulse", pe_cnt - fe0, 1);
        chk("par_bad_no_dv", dv_cnt - dv0, 0);
        chk("par_bad_empty", o_empty, 1);
`else
        chk("par_tied", pe_cnt, 0);
`endif

        chk("dv_fe_exclusive", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
